// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between the sequencer and memory.
// Memory may stretch any request by holding mem_ready low.
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic mem_sel_d;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output mem_sel_d, input mem_ready);
   modport slave  (input mem_req, input mem_we, input mem_sel_d, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// wait-state memory handshake, watchdog, retire counter and halt flags.
module multicycle_ctrl #(
   parameter int RET_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   multicycle_ctrl_if.master  bus,
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic               funct7_5,
   input  logic               zero,
   output logic               ir_we,
   output logic               pc_we,
   output logic               pc_src,
   output logic               alu_src_b,
   output logic [3:0]         alu_op,
   output logic               reg_we,
   output logic               wb_sel,
   output logic               halted,
   output logic               illegal,
   output logic               bus_err,
   output logic [RET_W-1:0]   retired,
   output logic [2:0]         state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [6:0]  OP_R    = 7'b0110011;
   localparam logic [6:0]  OP_I    = 7'b0010011;
   localparam logic [6:0]  OP_LD   = 7'b0000011;
   localparam logic [6:0]  OP_ST   = 7'b0100011;
   localparam logic [6:0]  OP_BR   = 7'b1100011;
   localparam logic [6:0]  OP_HALT = 7'b1111111;
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   state_t           st, st_nxt;
   logic [6:0]       op_p1;
   logic [2:0]       f3_p1;
   logic             f7_p1;
   logic [15:0]      wcnt;
   logic [RET_W-1:0] ret_cnt;
   logic             ill_q, berr_q;
   logic             req_c, we_c, seld_c, irwe_c, pcwe_c, pcsrc_c;
   logic             asb_c, regwe_c, wbsel_c;
   logic [3:0]       aop_c;
   logic             retire_c, set_ill_c, set_berr_c;
   logic             wd_expire;

   function automatic logic legal_op(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         OP_R, OP_I, OP_LD, OP_ST: legal_op = 1'b1;
         OP_BR:                    legal_op = (f3 == 3'b000) || (f3 == 3'b001);
         default:                  legal_op = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] alu_ctl(input logic [6:0] op, input logic [2:0] f3,
                                          input logic f7);
      case (op)
         OP_R:    alu_ctl = {f7, f3};
         OP_I:    alu_ctl = {(f3 == 3'b101) & f7, f3};
         OP_BR:   alu_ctl = 4'b1000;
         default: alu_ctl = 4'b0000;
      endcase
   endfunction

   // A miss on this cycle would bring the wait counter up to TIMEOUT.
   assign wd_expire = !bus.mem_ready && (wcnt == WD_LAST);

   always_comb begin
      st_nxt     = st;
      req_c      = 1'b0;
      we_c       = 1'b0;
      seld_c     = 1'b0;
      irwe_c     = 1'b0;
      pcwe_c     = 1'b0;
      pcsrc_c    = 1'b0;
      asb_c      = 1'b0;
      aop_c      = 4'b0000;
      regwe_c    = 1'b0;
      wbsel_c    = 1'b0;
      retire_c   = 1'b0;
      set_ill_c  = 1'b0;
      set_berr_c = 1'b0;
      case (st)
         S_FETCH: begin
            req_c = 1'b1;
            if (bus.mem_ready) begin
               irwe_c = 1'b1;
               pcwe_c = 1'b1;
               st_nxt = S_DECODE;
            end else if (wd_expire) begin
               set_berr_c = 1'b1;
               st_nxt     = S_HALT;
            end
         end
         S_DECODE: begin
            if (opcode == OP_HALT) begin
               st_nxt = S_HALT;
            end else if (legal_op(opcode, funct3)) begin
               st_nxt = S_EXEC;
            end else begin
               set_ill_c = 1'b1;
               st_nxt    = S_HALT;
            end
         end
         S_EXEC: begin
            asb_c = (op_p1 == OP_I) || (op_p1 == OP_LD) || (op_p1 == OP_ST);
            aop_c = alu_ctl(op_p1, f3_p1, f7_p1);
            case (op_p1)
               OP_BR: begin
                  // Only BEQ/BNE get here, so funct3[0] selects the sense of zero.
                  pcwe_c   = f3_p1[0] ? !zero : zero;
                  pcsrc_c  = pcwe_c;
                  retire_c = 1'b1;
                  st_nxt   = S_FETCH;
               end
               OP_R, OP_I:   st_nxt = S_WB;
               OP_LD, OP_ST: st_nxt = S_MEM;
               default:      st_nxt = S_HALT;
            endcase
         end
         S_MEM: begin
            req_c  = 1'b1;
            seld_c = 1'b1;
            we_c   = (op_p1 == OP_ST);
            if (bus.mem_ready) begin
               if (op_p1 == OP_ST) begin
                  retire_c = 1'b1;
                  st_nxt   = S_FETCH;
               end else begin
                  st_nxt = S_WB;
               end
            end else if (wd_expire) begin
               set_berr_c = 1'b1;
               st_nxt     = S_HALT;
            end
         end
         S_WB: begin
            regwe_c  = 1'b1;
            wbsel_c  = (op_p1 == OP_LD);
            retire_c = 1'b1;
            st_nxt   = S_FETCH;
         end
         S_HALT:  st_nxt = S_HALT;
         default: st_nxt = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= S_FETCH;
         wcnt    <= '0;
         ret_cnt <= '0;
         ill_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         st <= st_nxt;
         if (st_nxt != st && (st_nxt == S_FETCH || st_nxt == S_MEM))
            wcnt <= '0;
         else if (req_c && !bus.mem_ready)
            wcnt <= wcnt + 16'd1;
         if (retire_c)
            ret_cnt <= ret_cnt + RET_W'(1);
         if (set_ill_c)
            ill_q <= 1'b1;
         if (set_berr_c)
            berr_q <= 1'b1;
      end
   end

   // Instruction fields captured in DECODE; later states never look at the live inputs.
   always_ff @(posedge clk) begin
      if (st == S_DECODE) begin
         op_p1 <= opcode;
         f3_p1 <= funct3;
         f7_p1 <= funct7_5;
      end
   end

   // Reset masks every strobe combinationally so nothing is requested while rst_n is low.
   assign bus.mem_req   = rst_n & req_c;
   assign bus.mem_we    = rst_n & we_c;
   assign bus.mem_sel_d = rst_n & seld_c;
   assign ir_we         = rst_n & irwe_c;
   assign pc_we         = rst_n & pcwe_c;
   assign pc_src        = rst_n & pcsrc_c;
   assign alu_src_b     = rst_n & asb_c;
   assign alu_op        = rst_n ? aop_c : 4'b0000;
   assign reg_we        = rst_n & regwe_c;
   assign wb_sel        = rst_n & wbsel_c;
   assign halted        = rst_n & (st == S_HALT);
   assign illegal       = ill_q;
   assign bus_err       = berr_q;
   assign retired       = ret_cnt;
   assign state         = st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: a memory/IR responder drives
// the DUT, a reference model queues per-instruction outcomes, a monitor checks them.
module tb_multicycle_ctrl;
   localparam int RET_W = 4;
   localparam int TMO   = 4;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_HALT = 7'b1111111;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z;
      int         fw;
      int         mw;
   } instr_t;

   typedef struct {
      int               cyc;
      logic [3:0]       aop;
      logic             asb;
      logic             br;
      int               nreg;
      logic             wbs;
      logic             mwe;
      logic             halt;
      logic             ill;
      logic             berr;
      logic [RET_W-1:0] ret;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             funct7_5;
   logic             zero;
   logic             ir_we, pc_we, pc_src, alu_src_b, reg_we, wb_sel;
   logic             halted, illegal, bus_err;
   logic [3:0]       alu_op;
   logic [RET_W-1:0] retired;
   logic [2:0]       state;

   instr_t           prog[$];
   exp_t             exp_q[$];
   int               tot = 0;
   int               bad = 0;
   logic [RET_W-1:0] ret_model = '0;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.RET_W(RET_W), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .zero      (zero),
      .ir_we     (ir_we),
      .pc_we     (pc_we),
      .pc_src    (pc_src),
      .alu_src_b (alu_src_b),
      .alu_op    (alu_op),
      .reg_we    (reg_we),
      .wb_sel    (wb_sel),
      .halted    (halted),
      .illegal   (illegal),
      .bus_err   (bus_err),
      .retired   (retired),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic z, input int fw, input int mw);
      instr_t i;
      i.op = op; i.f3 = f3; i.f7 = f7; i.z = z; i.fw = fw; i.mw = mw;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      i = mk(OP_R, 3'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
      case ($urandom_range(0, 5))
         0: i.op = OP_R;
         1: i.op = OP_I;
         2: i.op = OP_LD;
         3: i.op = OP_ST;
         default: begin
            i.op = OP_BR;
            i.f3 = {2'b00, 1'($urandom)};
         end
      endcase
      return i;
   endfunction

   // Reference model: per-instruction outcome from the instruction-class rules.
   task automatic push_instr(input instr_t i);
      exp_t e;
      bit   is_ld, is_st, is_br, legal;
      is_ld = (i.op == OP_LD);
      is_st = (i.op == OP_ST);
      is_br = (i.op == OP_BR);
      legal = (i.op == OP_R) || (i.op == OP_I) || is_ld || is_st ||
              (is_br && (i.f3 == 3'd0 || i.f3 == 3'd1));
      e.cyc = 0; e.aop = 4'd0; e.asb = 1'b0; e.br = 1'b0; e.nreg = 0;
      e.wbs = 1'b0; e.mwe = 1'b0; e.halt = 1'b0; e.ill = 1'b0; e.berr = 1'b0;
      if (i.fw >= TMO) begin
         e.cyc = TMO; e.halt = 1'b1; e.berr = 1'b1;
      end else if (i.op == OP_HALT || !legal) begin
         e.cyc = 2 + i.fw; e.halt = 1'b1; e.ill = !legal && (i.op != OP_HALT);
      end else begin
         e.cyc = 3 + i.fw;
         e.asb = (i.op == OP_I) || is_ld || is_st;
         if (i.op == OP_R)      e.aop = {i.f7, i.f3};
         else if (i.op == OP_I) e.aop = (i.f3 == 3'd5) ? {i.f7, i.f3} : {1'b0, i.f3};
         else if (is_br)        e.aop = 4'b1000;
         if (is_br) e.br = (i.f3 == 3'd0) ? i.z : !i.z;
         if (is_ld || is_st) begin
            e.mwe = is_st;
            if (i.mw >= TMO) begin
               e.cyc += TMO; e.halt = 1'b1; e.berr = 1'b1;
            end else begin
               e.cyc += 1 + i.mw;
            end
         end
         if (!e.halt && !is_st && !is_br) begin
            e.cyc += 1; e.nreg = 1; e.wbs = is_ld;
         end
      end
      if (!e.halt) ret_model = ret_model + 1'b1;
      e.ret = ret_model;
      prog.push_back(i);
      exp_q.push_back(e);
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, int'({bus.mem_req, bus.mem_we, bus.mem_sel_d, ir_we, pc_we, pc_src, alu_src_b,
                    alu_op, reg_we, wb_sel, halted, illegal, bus_err, retired, state}), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3 rst_n = 1'b0;
      prog.delete();
      exp_q.delete();
      ret_model = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic drain(input string nm, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk); #2;
         n++;
      end
      chk({nm, "_drain"}, exp_q.size(), 0);
   endtask

   task automatic quiet(input string nm, input int ill, input int berr);
      repeat (10) begin
         @(negedge clk); #2;
         chk({nm, "_req_in_halt"}, int'(bus.mem_req), 0);
      end
      chk({nm, "_halted"}, int'(halted), 1);
      chk({nm, "_state"}, int'(state), 5);
      chk({nm, "_illegal"}, int'(illegal), ill);
      chk({nm, "_bus_err"}, int'(bus_err), berr);
   endtask

   // Memory and instruction-register responder.
   initial begin : responder
      instr_t cur;
      int     cnt, waits;
      bit     in_req;
      cur = mk(OP_HALT, 3'd0, 1'b0, 1'b0, 0, 0);
      cnt = 0; waits = 0; in_req = 0;
      bus.mem_ready = 1'b0;
      {opcode, funct3, funct7_5} = '0;
      zero = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_req = 0;
            bus.mem_ready = 1'b0;
            continue;
         end
         if (bus.mem_req) begin
            if (!in_req) begin
               in_req = 1; cnt = 0;
               if (state == 3'd0) begin
                  if (prog.size() != 0) cur = prog.pop_front();
                  else cur = mk(OP_HALT, 3'd0, 1'b0, 1'b0, 1000, 0);
                  waits = cur.fw;
               end else begin
                  waits = cur.mw;
               end
            end
            bus.mem_ready = (cnt == waits);
            cnt++;
            if (bus.mem_ready) in_req = 0;
         end else begin
            in_req = 0;
            bus.mem_ready = 1'($urandom);
         end
         if (state == 3'd1) {opcode, funct3, funct7_5} = {cur.op, cur.f3, cur.f7};
         else               {opcode, funct3, funct7_5} = 11'($urandom);
         zero = (state == 3'd2) ? cur.z : 1'($urandom);
      end
   end

   // Monitor: per-cycle strobe checks and per-instruction scoreboard compare.
   initial begin : monitor
      int         cyc, nreg;
      logic [3:0] aop;
      logic       asb, br, wbs;
      logic [2:0] prev;
      exp_t       e;
      cyc = 0; nreg = 0; aop = '0; asb = 0; br = 0; wbs = 0; prev = '0;
      forever begin
         @(negedge clk); #1;
         if (!rst_n) begin
            cyc = 0; nreg = 0; aop = '0; asb = 0; br = 0; wbs = 0; prev = '0;
            continue;
         end
         if ((prev != 3'd0 && state == 3'd0) || (prev != 3'd5 && state == 3'd5)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_completion", int'(state), -1);
            end else begin
               e = exp_q.pop_front();
               chk("cycles", cyc, e.cyc);
               chk("alu_op", int'(aop), int'(e.aop));
               chk("alu_src_b", int'(asb), int'(e.asb));
               chk("branch_taken", int'(br), int'(e.br));
               chk("reg_we_count", nreg, e.nreg);
               chk("wb_sel", int'(wbs), int'(e.wbs));
               chk("halted", int'(halted), int'(e.halt));
               chk("illegal", int'(illegal), int'(e.ill));
               chk("bus_err", int'(bus_err), int'(e.berr));
               chk("retired", int'(retired), int'(e.ret));
            end
            cyc = 0; nreg = 0; aop = '0; asb = 0; br = 0; wbs = 0;
         end
         if (state != 3'd5) begin
            cyc++;
            case (state)
               3'd0: chk("fetch_strobes",
                         int'({bus.mem_req, bus.mem_we, bus.mem_sel_d, ir_we, pc_we, pc_src, reg_we}),
                         int'({1'b1, 2'b00, bus.mem_ready, bus.mem_ready, 2'b00}));
               3'd1: chk("decode_strobes", int'({bus.mem_req, ir_we, pc_we, reg_we}), 0);
               3'd2: begin
                  aop = alu_op; asb = alu_src_b; br = pc_we;
                  chk("exec_strobes", int'({bus.mem_req, ir_we, reg_we, pc_src ^ pc_we}), 0);
               end
               3'd3: begin
                  chk("mem_req_sel", int'({bus.mem_req, bus.mem_sel_d, reg_we, ir_we}), 12);
                  if (exp_q.size() != 0) chk("mem_we", int'(bus.mem_we), int'(exp_q[0].mwe));
               end
               3'd4: begin
                  nreg += int'(reg_we);
                  wbs = wb_sel;
                  chk("wb_strobes", int'({bus.mem_req, ir_we, pc_we}), 0);
               end
               default: chk("state_code", int'(state), 0);
            endcase
         end
         prev = state;
      end
   end

   initial begin : main
      repeat (2) @(negedge clk);
      #2 chk_zero("reset_outputs");

      // Directed plan items, then a random legal stream ending on HALT.
      push_instr(mk(OP_R, 3'b000, 1'b0, 1'b0, 0, 0));
      push_instr(mk(OP_LD, 3'b010, 1'b0, 1'b0, 2, 1));
      push_instr(mk(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0));
      push_instr(mk(OP_BR, 3'b001, 1'b0, 1'b1, 0, 0));
      push_instr(mk(OP_I, 3'b101, 1'b1, 1'b0, 3, 0));
      push_instr(mk(OP_ST, 3'b010, 1'b0, 1'b0, 0, 3));
      repeat (40) push_instr(rand_instr());
      push_instr(mk(OP_HALT, 3'b000, 1'b0, 1'b0, 1, 0));
      release_reset();
      drain("stream", 3000);
      quiet("stream", 0, 0);

      do_reset();
      push_instr(mk(7'b1010101, 3'b000, 1'b0, 1'b0, 1, 0));
      release_reset();
      drain("illegal_op", 200);
      quiet("illegal_op", 1, 0);

      do_reset();
      push_instr(mk(OP_BR, 3'b010, 1'b0, 1'b0, 0, 0));
      release_reset();
      drain("illegal_br", 200);
      quiet("illegal_br", 1, 0);

      do_reset();
      push_instr(mk(OP_R, 3'b000, 1'b0, 1'b0, TMO, 0));
      release_reset();
      drain("fetch_timeout", 200);
      quiet("fetch_timeout", 0, 1);

      do_reset();
      push_instr(mk(OP_LD, 3'b000, 1'b0, 1'b0, 0, TMO));
      release_reset();
      drain("mem_timeout", 200);
      quiet("mem_timeout", 0, 1);

      // Asynchronous reset in the middle of a stretched fetch.
      do_reset();
      prog.push_back(mk(OP_R, 3'b000, 1'b0, 1'b0, TMO, 0));
      release_reset();
      repeat (2) @(negedge clk);
      #3 chk("wait_req", int'(bus.mem_req), 1);
      rst_n = 1'b0;
      #1 chk_zero("async_reset");
      repeat (2) @(negedge clk);
      #2 chk_zero("held_reset");

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32 datapath. It replaces single-cycle opcode decoding with a state machine that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It handshakes with a shared instruction/data memory port that may insert wait states, and it keeps a retired-instruction counter, a memory watchdog and halt/error flags.

## Interface
Parameters:
- RET_W, 32, width of retired-instruction counter
- TIMEOUT, 255, max cycles to wait for mem_ready before bus error (1..65535)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  7  instr[6:0] from instruction register; valid from DECODE onward
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- zero  in  1  ALU zero flag (combinational, valid in EXEC)
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request active
- mem_we  out  1  1 = write (store), 0 = read
- mem_sel_d  out  1  1 = data address (ALU result reg), 0 = PC
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- alu_src_b  out  1  0 = rs2, 1 = sign-extended immediate
- alu_op  out  4  {sub, funct3}
- reg_we  out  1  register file write
- wb_sel  out  1  0 = ALU result, 1 = memory data
- halted  out  1  in HALT state
- illegal  out  1  sticky: halted on illegal instruction
- bus_err  out  1  sticky: halted on memory timeout
- retired  out  RET_W  completed-instruction count
- state  out  3  current state (debug)

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to HALT on the next clock.
- Decoded opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, HALT 1111111. BRANCH is legal only with funct3 000 (BEQ) or 001 (BNE). Every other opcode or branch funct3 is illegal.
- The controller latches opcode, funct3 and funct7_5 internally in DECODE. EXEC, MEM and WB use the latched copies.
- FETCH: mem_req=1, mem_we=0, mem_sel_d=0. When mem_ready is high: ir_we=1, pc_we=1, pc_src=0, next state DECODE. Otherwise stay in FETCH.
- DECODE: no strobes. HALT opcode goes to HALT. Illegal opcode sets illegal and goes to HALT. All others go to EXEC.
- EXEC:
  - alu_src_b=1 for I-ALU, LOAD and STORE.
  - alu_op: R gives {funct7_5, funct3}; I-ALU gives {funct3==101 ? funct7_5 : 0, funct3}; LOAD and STORE give 0000; BRANCH gives 1000.
  - BRANCH: pc_we=pc_src=1 when (BEQ and zero) or (BNE and !zero); then go to FETCH and retire.
  - R and I-ALU go to WB. LOAD and STORE go to MEM.
- MEM: mem_req=1, mem_sel_d=1, mem_we=1 for STORE. When mem_ready is high: STORE goes to FETCH and retires; LOAD goes to WB.
- WB: reg_we=1, wb_sel=1 for LOAD. Go to FETCH and retire.
- Retire: `retired` increments by 1 on the state transition that completes an instruction. It wraps from all-ones to 0.
- Watchdog: a wait counter clears on entry to FETCH or MEM and increments each cycle that mem_req=1 and mem_ready=0. If it reaches TIMEOUT: set bus_err, drop mem_req, go to HALT.
- HALT: all strobes are 0 and halted=1. Only reset leaves HALT.
- All strobes not named for a state are 0 in that state.

## Timing
- Reset: state=FETCH and all counters and flags are 0. While rst_n=0 every output is forced to 0, including mem_req, so no request is issued during reset.
- Reset asserted mid-access: mem_req drops combinationally, the in-flight access is abandoned, and `retired` is not incremented.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle): BRANCH 3 cycles, R, I-ALU and STORE 4, LOAD 5. Each wait cycle adds 1.
- mem_req stays high and mem_we/mem_sel_d stay stable from the first request cycle until the mem_ready cycle inclusive. mem_ready while mem_req=0 is ignored.
- ir_we and pc_we in FETCH are single-cycle pulses coincident with mem_ready.
- The timeout boundary: mem_ready arriving in the same cycle the counter would reach TIMEOUT counts as success.

## Test plan
- R-type ADD (0110011, funct3 000, funct7_5 0), zero-wait memory → states 0,1,2,4,0; alu_op=0000 in EXEC; reg_we=1 for exactly one cycle; retired=1 after 4 cycles.
- LOAD with 2 wait cycles in FETCH and 1 in MEM → 8 cycles total; wb_sel=1 in WB; mem_sel_d=1 and mem_we=0 throughout MEM.
- BEQ with zero=1 → pc_we=pc_src=1 in EXEC. BNE with zero=1 → pc_we=0. Both return to FETCH after 3 cycles.
- Opcode 1010101 → DECODE goes to HALT; illegal=1, halted=1; mem_req stays 0 for the following 10 cycles. Same for BRANCH with funct3 010.
- TIMEOUT=4, mem_ready held low in FETCH → mem_req high for 4 cycles, then bus_err=1 and state=5. Deassert rst_n asynchronously mid-wait → all outputs 0 immediately, state=0.
- Preload retired to all-ones via a long STORE run (or force), retire one more instruction → retired wraps to 0.
